// File: rtl/accelerator_tensor_float_streamer.sv
// Tensor element source for the float adder/subtractor blocks.
// A host fills a small word buffer while idle; START replays it as a k/j/i-ordered
// stream with framing strobes, and HOLD lets the consumer stall the stream.
module accelerator_tensor_float_streamer #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4,
    parameter int ADDRESS_SIZE = 6
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    input  logic                    HOLD,
    input  logic                    WRITE_ENABLE,
    input  logic [ADDRESS_SIZE-1:0] WRITE_ADDRESS,
    input  logic [DATA_SIZE-1:0]    WRITE_DATA,
    input  logic [DATA_SIZE-1:0]    SIZE_I_IN,
    input  logic [DATA_SIZE-1:0]    SIZE_J_IN,
    input  logic [DATA_SIZE-1:0]    SIZE_K_IN,
    output logic                    DATA_OUT_I_ENABLE,
    output logic                    DATA_OUT_J_ENABLE,
    output logic                    DATA_OUT_K_ENABLE,
    output logic [DATA_SIZE-1:0]    DATA_OUT
);

    localparam int DEPTH = 2 ** ADDRESS_SIZE;
    localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(1);

    typedef enum logic [1:0] {
        STARTER_STATE,
        STREAM_STATE,
        ENDER_STATE
    } state_t;

    state_t                  state;
    logic [DATA_SIZE-1:0]    buffer [DEPTH];
    logic [DATA_SIZE-1:0]    size_i;
    logic [DATA_SIZE-1:0]    size_j;
    logic [DATA_SIZE-1:0]    size_k;
    logic [DATA_SIZE-1:0]    index_i;
    logic [DATA_SIZE-1:0]    index_j;
    logic [DATA_SIZE-1:0]    index_k;
    logic [ADDRESS_SIZE-1:0] address;
    logic                    last_i;
    logic                    last_j;
    logic                    last_k;

    assign last_k = (index_k == size_k - ONE);
    assign last_j = (index_j == size_j - ONE);
    assign last_i = (index_i == size_i - ONE);

    // Host writes land only while idle so a running stream never sees its data change
    always_ff @(posedge CLK) begin
        if (WRITE_ENABLE && state == STARTER_STATE) begin
            buffer[WRITE_ADDRESS] <= WRITE_DATA;
        end
    end

    // Sequencer: latch sizes on START, walk k then j then i, then pulse READY once
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state             <= STARTER_STATE;
            size_i            <= '0;
            size_j            <= '0;
            size_k            <= '0;
            index_i           <= '0;
            index_j           <= '0;
            index_k           <= '0;
            address           <= '0;
            READY             <= 1'b0;
            DATA_OUT_I_ENABLE <= 1'b0;
            DATA_OUT_J_ENABLE <= 1'b0;
            DATA_OUT_K_ENABLE <= 1'b0;
            DATA_OUT          <= '0;
        end else begin
            READY             <= 1'b0;
            DATA_OUT_I_ENABLE <= 1'b0;
            DATA_OUT_J_ENABLE <= 1'b0;
            DATA_OUT_K_ENABLE <= 1'b0;
            case (state)
                STARTER_STATE: begin
                    if (START) begin
                        size_i  <= SIZE_I_IN;
                        size_j  <= SIZE_J_IN;
                        size_k  <= SIZE_K_IN;
                        index_i <= '0;
                        index_j <= '0;
                        index_k <= '0;
                        address <= '0;
                        if (SIZE_I_IN == '0 || SIZE_J_IN == '0 || SIZE_K_IN == '0) begin
                            state <= ENDER_STATE;
                        end else begin
                            state <= STREAM_STATE;
                        end
                    end
                end
                STREAM_STATE: begin
                    if (!HOLD) begin
                        DATA_OUT          <= buffer[address];
                        DATA_OUT_K_ENABLE <= 1'b1;
                        DATA_OUT_J_ENABLE <= (index_k == '0);
                        DATA_OUT_I_ENABLE <= (index_j == '0) && (index_k == '0);
                        address           <= address + ADDRESS_SIZE'(1);
                        if (last_k) begin
                            index_k <= '0;
                            if (last_j) begin
                                index_j <= '0;
                                if (last_i) begin
                                    index_i <= '0;
                                    state   <= ENDER_STATE;
                                end else begin
                                    index_i <= index_i + ONE;
                                end
                            end else begin
                                index_j <= index_j + ONE;
                            end
                        end else begin
                            index_k <= index_k + ONE;
                        end
                    end
                end
                ENDER_STATE: begin
                    READY <= 1'b1;
                    state <= STARTER_STATE;
                end
                default: begin
                    state <= STARTER_STATE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accelerator_tensor_float_streamer.sv
// Bench for the tensor float streamer: a buffer/loop model predicts every output cycle,
// a single compare process checks it, and directed runs pin the model with literal values.
module tb_accelerator_tensor_float_streamer;

    localparam int DATA_SIZE    = 64;
    localparam int ADDRESS_SIZE = 6;
    localparam int DEPTH        = 2 ** ADDRESS_SIZE;

    typedef struct packed {
        logic [DATA_SIZE-1:0] data;
        logic                 i_en;
        logic                 j_en;
        logic                 k_en;
        logic                 ready;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic                    hold;
    logic                    write_enable;
    logic [ADDRESS_SIZE-1:0] write_address;
    logic [DATA_SIZE-1:0]    write_data;
    logic [DATA_SIZE-1:0]    size_i;
    logic [DATA_SIZE-1:0]    size_j;
    logic [DATA_SIZE-1:0]    size_k;
    logic                    ready;
    logic                    i_enable;
    logic                    j_enable;
    logic                    k_enable;
    logic [DATA_SIZE-1:0]    data_out;

    int checks = 0;
    int failures = 0;
    int cycle_ctr = 0;
    int start_cycle = 0;
    int first_k_cycle = -1;
    int ready_cycle = -1;
    int ready_count = 0;

    logic [DATA_SIZE-1:0] mem_model [DEPTH];
    logic [DATA_SIZE-1:0] last_data = '0;
    exp_t                 exp_q [$];
    exp_t                 cur;
    logic [DATA_SIZE-1:0] seen_data [$];
    logic                 seen_i [$];
    logic                 seen_j [$];
    logic [15:0]          i_mask;
    logic [15:0]          j_mask;

    accelerator_tensor_float_streamer #(
        .DATA_SIZE   (DATA_SIZE),
        .CONTROL_SIZE(4),
        .ADDRESS_SIZE(ADDRESS_SIZE)
    ) dut (
        .CLK              (clk),
        .RST              (rst),
        .START            (start),
        .READY            (ready),
        .HOLD             (hold),
        .WRITE_ENABLE     (write_enable),
        .WRITE_ADDRESS    (write_address),
        .WRITE_DATA       (write_data),
        .SIZE_I_IN        (size_i),
        .SIZE_J_IN        (size_j),
        .SIZE_K_IN        (size_k),
        .DATA_OUT_I_ENABLE(i_enable),
        .DATA_OUT_J_ENABLE(j_enable),
        .DATA_OUT_K_ENABLE(k_enable),
        .DATA_OUT         (data_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DATA_SIZE-1:0] actual,
                               input logic [DATA_SIZE-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [DATA_SIZE-1:0] seenAt(input int n);
        if (n < seen_data.size()) return seen_data[n];
        return 'x;
    endfunction

    task automatic pushExp(input logic [DATA_SIZE-1:0] d, input logic ie, input logic je,
                           input logic ke, input logic r);
        exp_t e;
        e.data  = d;
        e.i_en  = ie;
        e.j_en  = je;
        e.k_en  = ke;
        e.ready = r;
        exp_q.push_back(e);
    endtask

    // Compare process: every queued expectation is checked just after its clock edge
    always @(posedge clk) begin
        cycle_ctr++;
        #2;
        if (ready === 1'b1) begin
            ready_count++;
            ready_cycle = cycle_ctr;
        end
        if (k_enable === 1'b1) begin
            if (first_k_cycle < 0) first_k_cycle = cycle_ctr;
            seen_data.push_back(data_out);
            seen_i.push_back(i_enable);
            seen_j.push_back(j_enable);
        end
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            checkOutput("data_out", data_out, cur.data);
            checkOutput("i_enable", DATA_SIZE'(i_enable), DATA_SIZE'(cur.i_en));
            checkOutput("j_enable", DATA_SIZE'(j_enable), DATA_SIZE'(cur.j_en));
            checkOutput("k_enable", DATA_SIZE'(k_enable), DATA_SIZE'(cur.k_en));
            checkOutput("ready", DATA_SIZE'(ready), DATA_SIZE'(cur.ready));
        end
    end

    task automatic idleCycle();
        @(negedge clk);
        start        = 1'b0;
        hold         = 1'($urandom_range(1));
        write_enable = 1'b0;
        pushExp(last_data, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic writeWord(input int a, input logic [DATA_SIZE-1:0] d);
        @(negedge clk);
        start         = 1'b0;
        hold          = 1'b0;
        write_enable  = 1'b1;
        write_address = ADDRESS_SIZE'(a);
        write_data    = d;
        mem_model[a]  = d;
        pushExp(last_data, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One START-to-READY run; the expected element list comes from nested i/j/k loops
    task automatic applyStimulus(input logic [DATA_SIZE-1:0] si, input logic [DATA_SIZE-1:0] sj,
                                 input logic [DATA_SIZE-1:0] sk, input int hold_pct,
                                 input int hold_at, input int hold_len, input bit disturb,
                                 input int reset_after, input bit same_edge_write);
        exp_t            elems [$];
        exp_t            e;
        int              emitted;
        int              held;
        logic            h;
        longint unsigned lin;
        seen_data.delete();
        seen_i.delete();
        seen_j.delete();
        ready_count   = 0;
        first_k_cycle = -1;
        ready_cycle   = -1;
        @(negedge clk);
        start         = 1'b1;
        hold          = 1'($urandom_range(1));
        write_enable  = same_edge_write;
        write_address = '0;
        write_data    = 64'hCAFE_F00D_1234_5678;
        size_i        = si;
        size_j        = sj;
        size_k        = sk;
        if (same_edge_write) mem_model[0] = 64'hCAFE_F00D_1234_5678;
        start_cycle = cycle_ctr + 1;
        pushExp(last_data, 1'b0, 1'b0, 1'b0, 1'b0);
        lin = 0;
        if (si != 0 && sj != 0 && sk != 0) begin
            for (longint unsigned i = 0; i < si; i++) begin
                for (longint unsigned j = 0; j < sj; j++) begin
                    for (longint unsigned k = 0; k < sk; k++) begin
                        e.data  = mem_model[lin % DEPTH];
                        e.i_en  = (j == 0) && (k == 0);
                        e.j_en  = (k == 0);
                        e.k_en  = 1'b1;
                        e.ready = 1'b0;
                        elems.push_back(e);
                        lin++;
                    end
                end
            end
        end
        emitted = 0;
        held    = 0;
        while (emitted < elems.size()) begin
            if (reset_after >= 0 && emitted == reset_after) begin
                @(negedge clk);
                rst          = 1'b1;
                start        = 1'b0;
                hold         = 1'b0;
                write_enable = 1'b0;
                last_data    = '0;
                pushExp('0, 1'b0, 1'b0, 1'b0, 1'b0);
                #1;
                checkOutput("reset_data", data_out, '0);
                checkOutput("reset_k_enable", DATA_SIZE'(k_enable), '0);
                checkOutput("reset_ready", DATA_SIZE'(ready), '0);
                @(negedge clk);
                rst = 1'b0;
                pushExp(last_data, 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (hold_len > 0) begin
                h = (emitted == hold_at) && (held < hold_len);
                if (h) held++;
            end else begin
                h = ($urandom_range(99) < hold_pct);
            end
            @(negedge clk);
            hold          = h;
            start         = disturb ? 1'($urandom_range(1)) : 1'b0;
            write_enable  = disturb ? 1'($urandom_range(1)) : 1'b0;
            write_address = ADDRESS_SIZE'($urandom_range(DEPTH - 1));
            write_data    = {$urandom, $urandom};
            if (disturb) begin
                size_i = DATA_SIZE'($urandom_range(7));
                size_j = DATA_SIZE'($urandom_range(7));
                size_k = DATA_SIZE'($urandom_range(7));
            end
            if (h) begin
                pushExp(last_data, 1'b0, 1'b0, 1'b0, 1'b0);
            end else begin
                exp_q.push_back(elems[emitted]);
                last_data = elems[emitted].data;
                emitted++;
            end
        end
        @(negedge clk);
        hold          = 1'($urandom_range(1));
        start         = disturb ? 1'($urandom_range(1)) : 1'b0;
        write_enable  = disturb ? 1'($urandom_range(1)) : 1'b0;
        write_address = ADDRESS_SIZE'($urandom_range(DEPTH - 1));
        write_data    = {$urandom, $urandom};
        pushExp(last_data, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic buildMasks();
        i_mask = '0;
        j_mask = '0;
        foreach (seen_i[n]) begin
            if (n < 16) begin
                i_mask[n] = seen_i[n];
                j_mask[n] = seen_j[n];
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        hold          = 1'b0;
        write_enable  = 1'b0;
        write_address = '0;
        write_data    = '0;
        size_i        = '0;
        size_j        = '0;
        size_k        = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_data", data_out, '0);
        checkOutput("rst_ready", DATA_SIZE'(ready), '0);
        checkOutput("rst_enables", DATA_SIZE'({i_enable, j_enable, k_enable}), '0);
        rst = 1'b0;

        for (int a = 0; a < DEPTH; a++) writeWord(a, {$urandom, $urandom});
        for (int a = 0; a < 8; a++) writeWord(a, 64'h10 + 64'(a));
        idleCycle();

        // Basic 2x2x2 run
        applyStimulus(2, 2, 2, 0, 0, 0, 1'b0, -1, 1'b0);
        idleCycle();
        idleCycle();
        buildMasks();
        checkOutput("t1_count", 64'(seen_data.size()), 64'd8);
        for (int n = 0; n < 8; n++) checkOutput("t1_data", seenAt(n), 64'h10 + 64'(n));
        checkOutput("t1_i_mask", 64'(i_mask), 64'h0011);
        checkOutput("t1_j_mask", 64'(j_mask), 64'h0055);
        checkOutput("t1_first_latency", 64'(first_k_cycle - start_cycle), 64'd1);
        checkOutput("t1_ready_latency", 64'(ready_cycle - start_cycle), 64'd9);
        checkOutput("t1_ready_count", 64'(ready_count), 64'd1);

        // 1x3x2 with a two-cycle stall after element 2
        applyStimulus(1, 3, 2, 0, 3, 2, 1'b0, -1, 1'b0);
        idleCycle();
        idleCycle();
        checkOutput("t2_count", 64'(seen_data.size()), 64'd6);
        for (int n = 0; n < 6; n++) checkOutput("t2_data", seenAt(n), 64'h10 + 64'(n));
        checkOutput("t2_ready_latency", 64'(ready_cycle - start_cycle), 64'd9);

        // Zero size goes straight to READY
        applyStimulus(0, 4, 4, 0, 0, 0, 1'b0, -1, 1'b0);
        idleCycle();
        idleCycle();
        checkOutput("t3_count", 64'(seen_data.size()), 64'd0);
        checkOutput("t3_ready_latency", 64'(ready_cycle - start_cycle), 64'd1);
        checkOutput("t3_ready_count", 64'(ready_count), 64'd1);

        // Address wrap past the buffer depth
        applyStimulus(1, 1, 66, 0, 0, 0, 1'b0, -1, 1'b0);
        idleCycle();
        idleCycle();
        checkOutput("t4_count", 64'(seen_data.size()), 64'd66);
        checkOutput("t4_wrap0", seenAt(64), 64'h10);
        checkOutput("t4_wrap1", seenAt(65), 64'h11);

        // Writes, START and size changes while streaming are ignored
        applyStimulus(2, 2, 2, 0, 0, 0, 1'b1, -1, 1'b0);
        idleCycle();
        idleCycle();
        checkOutput("t5_count", 64'(seen_data.size()), 64'd8);
        checkOutput("t5_ready_count", 64'(ready_count), 64'd1);
        applyStimulus(2, 2, 2, 0, 0, 0, 1'b0, -1, 1'b0);
        idleCycle();
        idleCycle();
        checkOutput("t5_rerun_first", seenAt(0), 64'h10);
        checkOutput("t5_rerun_last", seenAt(7), 64'h17);

        // Reset in the middle of a 12-element stream
        applyStimulus(1, 3, 4, 0, 0, 0, 1'b0, 4, 1'b0);
        idleCycle();
        idleCycle();
        checkOutput("t6_ready_count", 64'(ready_count), 64'd0);
        checkOutput("t6_count", 64'(seen_data.size()), 64'd4);
        applyStimulus(1, 3, 4, 0, 0, 0, 1'b0, -1, 1'b0);
        idleCycle();
        idleCycle();
        checkOutput("t6_restart_first", seenAt(0), 64'h10);
        checkOutput("t6_restart_count", 64'(seen_data.size()), 64'd12);

        // Write and START on the same edge: the stream sees the new word
        applyStimulus(1, 1, 2, 0, 0, 0, 1'b0, -1, 1'b1);
        idleCycle();
        idleCycle();
        checkOutput("t7_new_word", seenAt(0), 64'hCAFE_F00D_1234_5678);
        checkOutput("t7_next_word", seenAt(1), 64'h11);
        writeWord(0, 64'h10);

        // Randomized runs against the model
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(1) == 1) writeWord(int'($urandom_range(DEPTH - 1)), {$urandom, $urandom});
            applyStimulus(DATA_SIZE'($urandom_range(4)), DATA_SIZE'($urandom_range(4)),
                          DATA_SIZE'($urandom_range(5)), 30, 0, 0, 1'($urandom_range(1)),
                          ($urandom_range(7) == 0) ? int'($urandom_range(5)) : -1,
                          ($urandom_range(7) == 0));
            idleCycle();
        end
        idleCycle();
        idleCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
